// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator: state encodings,
// idle line level default and the registered serial output bundle.
package serial_pattern_gen_pkg;

    // Controller state encodings (IDLE=0, SHIFT=1, GAP=2)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Level driven on sdata whenever no pattern bit is active
    localparam logic IDLE_LEVEL_DEF = 1'b0;

    // Registered serial output bundle presented to the detector
    typedef struct packed {
        logic sdata;
        logic bit_valid;
        logic done;
    } ser_out_t;

endpackage : serial_pattern_gen_pkg

// File: rtl/serial_pattern_gen_bit_down_counter.sv
// Loadable down counter with zero flag; used for bit and gap counting.
module bit_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count  = cnt_q;
    assign zero_c = (cnt_q == '0);

endmodule : bit_down_counter

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: loads a parallel word and shifts it out MSB-first
// on sdata, optionally repeating it with an idle gap until stopped.
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [WIDTH-1:0]             data,
    input  logic [$clog2(WIDTH+1)-1:0]   nbits,
    input  logic                         repeat_en,
    input  logic                         stop,
    output logic                         ready,
    output logic                         busy,
    output logic                         sdata,
    output logic                         bit_valid,
    output logic                         done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD =
        (GAP_CYCLES == 0) ? GW'(0) : GW'(GAP_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    len_q, len_d;
    logic             rep_q, rep_d;
    logic             busy_q, busy_d;
    ser_out_t         out_q, out_d;

    logic [CW-1:0]    nb_eff;
    logic [WIDTH-1:0] aligned;
    logic             restart;

    logic             bc_load, bc_dec, bc_zero;
    logic [CW-1:0]    bc_val, bc_count;
    logic             gc_load, gc_dec, gc_zero;
    logic [GW-1:0]    gc_count_unused;

    // Bit counter: bits remaining after the one currently on sdata
    bit_down_counter #(.W(CW)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bc_load),
        .load_val (bc_val),
        .dec      (bc_dec),
        .count    (bc_count),
        .zero_c   (bc_zero)
    );

    // Gap counter: idle cycles remaining between repeated passes
    bit_down_counter #(.W(GW)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gc_load),
        .load_val (GAP_LOAD),
        .dec      (gc_dec),
        .count    (gc_count_unused),
        .zero_c   (gc_zero)
    );

    // Clamp requested length and left-align the pattern so its first bit is the MSB
    always_comb begin
        nb_eff  = (nbits > CW'(WIDTH)) ? CW'(WIDTH) : nbits;
        aligned = data << (CW'(WIDTH) - nb_eff);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        sh_d          = sh_q;
        len_d         = len_q;
        rep_d         = rep_q;
        out_d         = '{sdata: IDLE_LEVEL, bit_valid: 1'b0, done: 1'b0};
        bc_load       = 1'b0;
        bc_val        = '0;
        bc_dec        = 1'b0;
        gc_load       = 1'b0;
        gc_dec        = 1'b0;
        restart       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load && (nbits != '0)) begin
                    state_d         = ST_SHIFT;
                    pat_d           = aligned;
                    sh_d            = {aligned[WIDTH-2:0], 1'b0};
                    len_d           = nb_eff;
                    rep_d           = repeat_en;
                    out_d.sdata     = aligned[WIDTH-1];
                    out_d.bit_valid = 1'b1;
                    out_d.done      = (nb_eff == CW'(1));
                    bc_load         = 1'b1;
                    bc_val          = nb_eff - CW'(1);
                end
            end
            ST_SHIFT: begin
                if (stop) begin
                    rep_d = 1'b0;
                end
                if (!bc_zero) begin
                    out_d.sdata     = sh_q[WIDTH-1];
                    out_d.bit_valid = 1'b1;
                    out_d.done      = (bc_count == CW'(1));
                    sh_d            = {sh_q[WIDTH-2:0], 1'b0};
                    bc_dec          = 1'b1;
                end else if (rep_q && !stop) begin
                    if (GAP_CYCLES == 0) begin
                        restart = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        gc_load = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    rep_d   = 1'b0;
                end else if (gc_zero) begin
                    restart = 1'b1;
                end else begin
                    gc_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Re-send the latched pattern from its first bit
        if (restart) begin
            state_d         = ST_SHIFT;
            out_d.sdata     = pat_q[WIDTH-1];
            out_d.bit_valid = 1'b1;
            out_d.done      = (len_q == CW'(1));
            sh_d            = {pat_q[WIDTH-2:0], 1'b0};
            bc_load         = 1'b1;
            bc_val          = len_q - CW'(1);
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
            out_q   <= '{sdata: IDLE_LEVEL, bit_valid: 1'b0, done: 1'b0};
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
        end
    end

    assign busy      = busy_q;
    assign ready     = ~busy_q;
    assign sdata     = out_q.sdata;
    assign bit_valid = out_q.bit_valid;
    assign done      = out_q.done;

endmodule : serial_pattern_gen

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen (WIDTH=8, GAP_CYCLES=2, IDLE_LEVEL=0).
module tb_serial_pattern_gen;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] data;
    logic [3:0] nbits;
    logic       repeat_en;
    logic       stop;
    logic       ready, busy, sdata, bit_valid, done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    serial_pattern_gen #(.WIDTH(8), .GAP_CYCLES(GAP), .IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data      (data),
        .nbits     (nbits),
        .repeat_en (repeat_en),
        .stop      (stop),
        .ready     (ready),
        .busy      (busy),
        .sdata     (sdata),
        .bit_valid (bit_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of the per-cycle outputs still to be shown
    typedef struct packed {
        logic gap;
        logic sd;
        logic vl;
        logic dn;
    } ent_t;

    ent_t       mq[$];
    ent_t       cur;
    bit         m_busy;
    bit         m_rep;
    logic [7:0] m_data;
    int         m_len;

    function automatic ent_t mk(input logic g, input logic s, input logic v, input logic d);
        ent_t e;
        e.gap = g; e.sd = s; e.vl = v; e.dn = d;
        return e;
    endfunction

    function automatic void push_pass(input logic [7:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) mq.push_back(mk(1'b0, d[i], 1'b1, i == 0));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            cur    = mk(1'b0, 1'b0, 1'b0, 1'b0);
            m_busy = 1'b0;
            m_rep  = 1'b0;
        end else begin
            if (!m_busy) begin
                if (load && nbits != 0) begin
                    m_len  = (nbits > 8) ? 8 : int'(nbits);
                    m_data = data;
                    m_rep  = repeat_en;
                    push_pass(m_data, m_len);
                end
            end else begin
                if (stop) begin
                    m_rep = 1'b0;
                    if (cur.gap) mq.delete();
                end
                if (mq.size() == 0 && m_rep) begin
                    for (int g = 0; g < GAP; g++) mq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
                    push_pass(m_data, m_len);
                end
            end
            if (mq.size() > 0) begin
                cur    = mq.pop_front();
                m_busy = 1'b1;
            end else begin
                cur    = mk(1'b0, 1'b0, 1'b0, 1'b0);
                m_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_sdata", sdata, cur.sd);
            chk("model_bit_valid", bit_valid, cur.vl);
            chk("model_done", done, cur.dn);
            chk("model_busy", busy, m_busy);
            chk("model_ready", ready, !m_busy);
        end
    end

    // Check n consecutive cycles against MSB-first literal strings; ends on the last cycle
    task automatic expect_stream(input string nm, input logic [15:0] sd, input logic [15:0] vl,
                                 input logic [15:0] dn, input int n);
        for (int i = 0; i < n; i++) begin
            chk({nm, "_sdata"}, sdata, sd[n-1-i]);
            chk({nm, "_valid"}, bit_valid, vl[n-1-i]);
            chk({nm, "_done"}, done, dn[n-1-i]);
            if (i < n - 1) @(negedge clk);
        end
    endtask

    // Start a pattern from IDLE; returns at the cycle showing the first bit
    task automatic start(input logic [7:0] d, input logic [3:0] n, input logic rep);
        @(negedge clk);
        load = 1'b1; data = d; nbits = n; repeat_en = rep;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_ready_timeout"}, ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; data = '0; nbits = '0; repeat_en = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("reset_ready", ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_sdata", sdata, 1'b0);
        chk("reset_valid", bit_valid, 1'b0);

        // Full-width pattern, latency one edge, ready after last bit
        start(8'b1011_0010, 4'd8, 1'b0);
        expect_stream("t1", 16'b1_0110_0100, 16'b1_1111_1110, 16'b0_0000_0010, 9);
        chk("t1_ready", ready, 1'b1);

        // Short pattern uses the low nbits of data
        start(8'b1010_1110, 4'd3, 1'b0);
        expect_stream("t2", 16'b1100, 16'b1110, 16'b0010, 4);

        // Repeat mode with a two-cycle gap, then stop mid-pass
        start(8'hAD, 4'd4, 1'b1);
        expect_stream("t3rep", 16'b1101_0011_0100, 16'b1111_0011_1100, 16'b0001_0000_0100, 12);
        @(negedge clk);
        stop = 1'b1;
        expect_stream("t3stop", 16'b11010, 16'b11110, 16'b00010, 5);
        stop = 1'b0;
        chk("t3_idle", ready, 1'b1);

        // Stop during the gap returns to IDLE on the next edge
        start(8'h05, 4'd2, 1'b1);
        expect_stream("t3gap", 16'b010, 16'b110, 16'b010, 3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t3gap_ready", ready, 1'b1);
        chk("t3gap_valid", bit_valid, 1'b0);

        // Load while busy is ignored
        start(8'hF0, 4'd8, 1'b0);
        load = 1'b1; data = 8'h0F; nbits = 4'd3;
        expect_stream("t4", 16'b1_1110_0000, 16'b1_1111_1110, 16'b0_0000_0010, 9);
        load = 1'b0;

        // Length clamped to WIDTH; zero length ignored
        start(8'hA5, 4'd15, 1'b0);
        expect_stream("clamp", 16'b1_0100_1010, 16'b1_1111_1110, 16'b0_0000_0010, 9);
        start(8'hFF, 4'd0, 1'b0);
        chk("nbits0_ready", ready, 1'b1);
        chk("nbits0_valid", bit_valid, 1'b0);

        // Stop and load together in IDLE: load wins
        @(negedge clk);
        stop = 1'b1;
        start(8'h03, 4'd2, 1'b0);
        stop = 1'b0;
        expect_stream("stopload", 16'b110, 16'b110, 16'b010, 3);

        // Asynchronous reset mid-pattern
        start(8'b1101_1011, 4'd8, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sdata", sdata, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", ready, 1'b1);
        chk("arst_valid", bit_valid, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start(8'h81, 4'd8, 1'b0);
        expect_stream("post_rst", 16'b1_0000_0010, 16'b1_1111_1110, 16'b0_0000_0010, 9);

        // Detector stimulus stream
        start(8'b1110_0110, 4'd8, 1'b0);
        expect_stream("det", 16'b1_1100_1100, 16'b1_1111_1110, 16'b0_0000_0010, 9);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            load      = ($urandom_range(0, 3) == 0);
            data      = 8'($urandom);
            nbits     = 4'($urandom_range(0, 15));
            repeat_en = 1'($urandom_range(0, 1));
            stop      = ($urandom_range(0, 11) == 0);
        end
        @(negedge clk);
        load = 1'b0;
        stop = 1'b1;
        wait_ready("drain");
        stop = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_pattern_gen
